// File: rtl/uart_mm_loader.sv
// rtl/uart_mm_loader.sv - UART boot loader that writes a framed, checksummed image into main memory
module uart_mm_loader #(
  parameter int clk_freq  = 50000000,
  parameter int baud      = 115200,
  parameter int max_words = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        mm_wr,
  output logic [31:0] mm_address,
  output logic [31:0] mm_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  // Oversampling divider: 16 ticks per bit, truncated.
  localparam int DIV = clk_freq / (baud * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [16:0]   MAX_W    = 17'(max_words);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_SYNC, S_CNT_H, S_CNT_L, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR} ld_state_t;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DW-1:0]   div_cnt_q;
  logic            tick;
  rx_state_t       rx_state_q;
  logic [3:0]      tick_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      rx_shift_q;
  logic            byte_valid_q;
  logic            frame_err_q;
  logic [7:0]      rx_byte;

  ld_state_t       state_q;
  logic [7:0]      cnt_h_q;
  logic [15:0]     count_q;
  logic [1:0]      idx_q;
  logic [31:0]     word_q;
  logic [7:0]      xor_q;
  logic [15:0]     words_q;
  logic            mm_wr_q;
  logic [31:0]     mm_addr_q;
  logic [31:0]     mm_data_q;
  logic            done_q;
  logic            err_q;
  logic            hold_q;
  logic [15:0]     new_count;

  assign rx_byte      = rx_shift_q;
  assign new_count    = {cnt_h_q, rx_byte};
  assign tick         = (rx_state_q != RX_IDLE) && (div_cnt_q == DIV_LAST);
  assign mm_wr        = mm_wr_q;
  assign mm_address   = mm_addr_q;
  assign mm_data      = mm_data_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

  // Two-flop synchronizer plus one extra stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Baud divider, held at zero while idle so ticks align to the detected start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else if (rx_state_q == RX_IDLE || div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // 8N1 receiver: confirm start at mid-bit, sample data and stop at mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      rx_shift_q   <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            tick_cnt_q <= 4'd0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (tick_cnt_q == 4'd7) begin
              tick_cnt_q <= 4'd0;
              bit_cnt_q  <= 3'd0;
              rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (tick_cnt_q == 4'd15) begin
              tick_cnt_q <= 4'd0;
              rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
              if (bit_cnt_q == 3'd7) begin
                rx_state_q <= RX_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (tick_cnt_q == 4'd15) begin
              rx_state_q <= RX_IDLE;
              if (rx_sync_q) begin
                byte_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 4'd1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Frame parser and memory writer; outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_SYNC;
      cnt_h_q   <= 8'd0;
      count_q   <= 16'd0;
      idx_q     <= 2'd0;
      word_q    <= 32'd0;
      xor_q     <= 8'd0;
      words_q   <= 16'd0;
      mm_wr_q   <= 1'b0;
      mm_addr_q <= 32'd0;
      mm_data_q <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      mm_wr_q <= 1'b0;
      if (frame_err_q && state_q != S_DONE) begin
        state_q <= S_ERR;
        err_q   <= 1'b1;
        hold_q  <= 1'b1;
      end else begin
        case (state_q)
          S_SYNC: begin
            if (byte_valid_q && rx_byte == SYNC_BYTE) begin
              xor_q   <= 8'd0;
              state_q <= S_CNT_H;
            end
          end
          S_CNT_H: begin
            if (byte_valid_q) begin
              cnt_h_q <= rx_byte;
              xor_q   <= xor_q ^ rx_byte;
              state_q <= S_CNT_L;
            end
          end
          S_CNT_L: begin
            if (byte_valid_q) begin
              count_q <= new_count;
              xor_q   <= xor_q ^ rx_byte;
              if ({1'b0, new_count} > MAX_W) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else if (new_count == 16'd0) begin
                state_q <= S_CHK;
              end else begin
                idx_q   <= 2'd0;
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (byte_valid_q) begin
              word_q <= {word_q[23:0], rx_byte};
              xor_q  <= xor_q ^ rx_byte;
              if (idx_q == 2'd3) begin
                state_q <= S_WRITE;
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end
          end
          S_WRITE: begin
            mm_wr_q   <= 1'b1;
            mm_addr_q <= {14'd0, words_q, 2'b00};
            mm_data_q <= word_q;
            words_q   <= words_q + 16'd1;
            if (words_q + 16'd1 == count_q) begin
              state_q <= S_CHK;
            end else begin
              idx_q   <= 2'd0;
              state_q <= S_DATA;
            end
          end
          S_CHK: begin
            if (byte_valid_q) begin
              if (rx_byte == xor_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
              end else begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          S_ERR: begin
            if (byte_valid_q && rx_byte == SYNC_BYTE) begin
              err_q   <= 1'b0;
              words_q <= 16'd0;
              xor_q   <= 8'd0;
              state_q <= S_CNT_H;
            end
          end
          default: state_q <= S_SYNC;
        endcase
      end
    end
  end

endmodule
